// File: rtl/shared_reg_arbiter_pkg.sv
// Shared types for the round-robin shared-register arbiter.
package shared_reg_arbiter_pkg;
  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;
endpackage

// File: rtl/flopr.sv
// Resettable WIDTH-bit register with asynchronous active-high clear.
module flopr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= '0;
    else       q <= d;
  end
endmodule

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// scanning upward with wrap at NREQ-1 (works for non-power-of-two NREQ).
module rr_picker #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req_i,
  input  logic [$clog2(NREQ)-1:0] ptr_i,
  output logic [NREQ-1:0]         gnt_o,
  output logic [$clog2(NREQ)-1:0] idx_o,
  output logic                    valid_o
);
  localparam int IDW = $clog2(NREQ);

  int j;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    j       = 0;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(ptr_i) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!valid_o && req_i[j]) begin
        gnt_o[j] = 1'b1;
        idx_o    = IDW'(j);
        valid_o  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit register among NREQ requesters,
// with per-requester lock for back-to-back burst writes.
module shared_reg_arbiter
  import shared_reg_arbiter_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int NREQ  = 4,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [NREQ-1:0]       req_i,
  input  logic [NREQ-1:0]       lock_i,
  input  logic [NREQ*WIDTH-1:0] wdata_i,
  output logic [NREQ-1:0]       gnt_o,
  output logic [WIDTH-1:0]      q_o,
  output logic [IDW-1:0]        q_owner_o,
  output logic                  q_valid_o,
  output logic                  busy_o
);
  arb_state_t       state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   q_owner_q;
  logic             q_valid_q;

  logic [NREQ-1:0]  pick_gnt;
  logic [IDW-1:0]   pick_idx;
  logic             pick_valid;

  logic [NREQ-1:0]  gnt;
  logic [IDW-1:0]   gnt_idx;
  logic             grant_valid;

  logic [WIDTH-1:0] wdata_arr [NREQ];
  logic [WIDTH-1:0] q_d;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign wdata_arr[gi] = wdata_i[gi*WIDTH +: WIDTH];
  end

  rr_picker #(.NREQ(NREQ)) u_picker (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  // While locked, the lock owner is the requester whose data sits in q.
  always_comb begin
    state_d     = state_q;
    gnt         = '0;
    gnt_idx     = pick_idx;
    grant_valid = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        gnt         = pick_gnt;
        grant_valid = pick_valid;
        if (pick_valid && lock_i[pick_idx]) state_d = ARB_LOCKED;
      end
      ARB_LOCKED: begin
        gnt_idx            = q_owner_q;
        grant_valid        = req_i[q_owner_q];
        gnt[q_owner_q]     = req_i[q_owner_q];
        if (!req_i[q_owner_q] || !lock_i[q_owner_q]) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
    if (reset_i) begin
      gnt         = '0;
      grant_valid = 1'b0;
    end
  end

  assign ptr_d = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
  assign q_d   = grant_valid ? wdata_arr[gnt_idx] : q_o;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= ARB_IDLE;
      ptr_q     <= '0;
      q_owner_q <= '0;
      q_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      q_valid_q <= grant_valid;
      if (grant_valid) begin
        ptr_q     <= ptr_d;
        q_owner_q <= gnt_idx;
      end
    end
  end

  flopr #(.WIDTH(WIDTH)) u_data (
    .clk   (clk_i),
    .reset (reset_i),
    .d     (q_d),
    .q     (q_o)
  );

  assign gnt_o     = gnt;
  assign q_owner_o = q_owner_q;
  assign q_valid_o = q_valid_q;
  assign busy_o    = (state_q == ARB_LOCKED);
endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// behavioural round-robin/lock model, and an NREQ=3 instance for wrap order.
module tb_shared_reg_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req, lock, gnt;
  logic [31:0] wdata;
  logic [7:0]  q;
  logic [1:0]  q_owner;
  logic        q_valid, busy;

  logic [2:0]  req3, lock3, gnt3;
  logic [23:0] wdata3;
  logic [7:0]  q3;
  logic [1:0]  q_owner3;
  logic        q_valid3, busy3;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [7:0] m_q;
  int         m_owner, m_ptr, m_lo;
  bit         m_valid, m_locked;

  always #5 clk = ~clk;

  shared_reg_arbiter #(.WIDTH(8), .NREQ(4)) dut (
    .clk_i(clk), .reset_i(reset), .req_i(req), .lock_i(lock), .wdata_i(wdata),
    .gnt_o(gnt), .q_o(q), .q_owner_o(q_owner), .q_valid_o(q_valid), .busy_o(busy)
  );

  shared_reg_arbiter #(.WIDTH(8), .NREQ(3)) dut3 (
    .clk_i(clk), .reset_i(reset), .req_i(req3), .lock_i(lock3), .wdata_i(wdata3),
    .gnt_o(gnt3), .q_o(q3), .q_owner_o(q_owner3), .q_valid_o(q_valid3), .busy_o(busy3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_q = 8'h00; m_owner = 0; m_ptr = 0; m_lo = 0; m_valid = 0; m_locked = 0;
  endfunction

  function automatic int model_pick(input logic [3:0] r);
    if (m_locked) return r[m_lo] ? m_lo : -1;
    for (int i = 0; i < 4; i++) begin
      int j = (m_ptr + i) % 4;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  // Drive one cycle, check the combinational grant, clock, check registers.
  task automatic step(input logic [3:0] r, input logic [3:0] l, output int k);
    logic [31:0] exp_g;
    req = r; lock = l;
    k = model_pick(r);
    exp_g = (k < 0) ? 32'd0 : (32'd1 << k);
    #1;
    chk("gnt", 32'(gnt), exp_g);
    @(posedge clk); #1;
    if (k >= 0) begin
      m_q = wdata[k*8 +: 8]; m_owner = k; m_valid = 1; m_ptr = (k + 1) % 4;
    end else begin
      m_valid = 0;
    end
    if (m_locked) begin
      if (!r[m_lo] || !l[m_lo]) m_locked = 0;
    end else if (k >= 0 && l[k]) begin
      m_locked = 1; m_lo = k;
    end
    chk("q", 32'(q), 32'(m_q));
    chk("q_owner", 32'(q_owner), 32'(m_owner));
    chk("q_valid", 32'(q_valid), 32'(m_valid));
    chk("busy", 32'(busy), 32'(m_locked));
    $display("step req=%b lock=%b grant=%0d q=%h owner=%0d valid=%b busy=%b",
             r, l, k, q, q_owner, q_valid, busy);
    @(negedge clk);
  endtask

  initial begin
    int k;
    logic [2:0] exp3 [4];
    logic [7:0] qs [4];
    int owners [5];

    // ---- reset state, requests high must not be granted
    reset = 1'b1; req = 4'b1111; lock = 4'b0000; wdata = 32'h44_22_33_11;
    req3 = 3'b111; lock3 = 3'b000; wdata3 = 24'hC3_B2_A1;
    model_reset();
    #2;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_q", 32'(q), 32'd0);
    chk("rst_owner", 32'(q_owner), 32'd0);
    chk("rst_valid", 32'(q_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_gnt3", 32'(gnt3), 32'd0);
    @(negedge clk);
    req = 4'b0000; req3 = 3'b000;
    reset = 1'b0;

    // ---- NREQ=3: move ptr to 2, then all request -> order 2,0,1,2
    req3 = 3'b010;
    #1 chk("n3_pre", 32'(gnt3), 32'b010);
    @(posedge clk); @(negedge clk);
    exp3 = '{3'b100, 3'b001, 3'b010, 3'b100};
    for (int c = 0; c < 4; c++) begin
      req3 = 3'b111;
      #1 chk("n3_order", 32'(gnt3), 32'(exp3[c]));
      $display("n3 cycle %0d gnt3=%b", c, gnt3);
      @(posedge clk); @(negedge clk);
    end
    req3 = 3'b000;

    // ---- plain round robin between requesters 0 and 2
    qs = '{8'h11, 8'h22, 8'h11, 8'h22};
    for (int c = 0; c < 4; c++) begin
      step(4'b0101, 4'b0000, k);
      chk("rr_grant", 32'(k), (c % 2 == 0) ? 32'd0 : 32'd2);
      chk("rr_q", 32'(q), 32'(qs[c]));
      chk("rr_valid", 32'(q_valid), 32'd1);
    end

    // ---- lock burst by requester 1 while 3 waits (ptr moved to 1 first)
    step(4'b0001, 4'b0000, k);
    wdata = 32'h33_44_55_66;
    owners = '{1, 1, 1, 1, 3};
    for (int c = 0; c < 5; c++) begin
      step(4'b1010, (c < 3) ? 4'b0010 : 4'b0000, k);
      chk("lk_owner", 32'(q_owner), 32'(owners[c]));
      chk("lk_busy", 32'(busy), (c < 3) ? 32'd1 : 32'd0);
    end

    // ---- abandoned lock by requester 2
    step(4'b0100, 4'b0100, k);
    chk("ab_busy", 32'(busy), 32'd1);
    step(4'b0001, 4'b0000, k);
    chk("ab_nogrant", 32'(k), 32'hFFFF_FFFF);
    chk("ab_idle", 32'(busy), 32'd0);
    chk("ab_valid", 32'(q_valid), 32'd0);
    step(4'b0001, 4'b0000, k);
    chk("ab_resume", 32'(k), 32'd0);

    // ---- asynchronous reset in the middle of a burst
    step(4'b0010, 4'b0010, k);
    req = 4'b0010; lock = 4'b0010;
    #1 chk("ar_pre_busy", 32'(busy), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("ar_q", 32'(q), 32'd0);
    chk("ar_owner", 32'(q_owner), 32'd0);
    chk("ar_valid", 32'(q_valid), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_gnt", 32'(gnt), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    wdata = 32'hDD_CC_BB_AA;
    step(4'b0001, 4'b0000, k);
    chk("ar_after_q", 32'(q), 32'hAA);

    // ---- idle: contents hold, no strobe, no grant
    for (int c = 0; c < 5; c++) begin
      step(4'b0000, 4'b0000, k);
      chk("idle_q", 32'(q), 32'hAA);
      chk("idle_valid", 32'(q_valid), 32'd0);
    end

    // ---- randomized traffic against the model
    for (int n = 0; n < 300; n++) begin
      wdata = $urandom;
      step(4'($urandom), 4'($urandom), k);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
